// File: rtl/vm_coin_acceptor.sv
// Coin front end: syncs and debounces three coin sensors, queues coins for vm2002.
// Ports: clk, hrst (async), srst (sync), sense_*, accept_en, vm_ready -> coins, reject, fifo_level, counters.
module vm_coin_acceptor #(
  parameter int DEBOUNCE   = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 8
) (
  input  logic                          clk,
  input  logic                          hrst,
  input  logic                          srst,
  input  logic                          sense_nickel,
  input  logic                          sense_dime,
  input  logic                          sense_quarter,
  input  logic                          accept_en,
  input  logic                          vm_ready,
  output logic [1:0]                    coins,
  output logic                          reject,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [CNT_W-1:0]              accepted_cnt,
  output logic [CNT_W-1:0]              rejected_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam logic [7:0] DB_LAST = 8'(DEBOUNCE - 1);
  localparam logic [LW-1:0] FULL = LW'(FIFO_DEPTH);

  logic [2:0] raw;
  logic [2:0] sync1;
  logic [2:0] sync2;
  logic [2:0] deb;
  logic [2:0] deb_d;
  logic [7:0] cnt [3];

  assign raw = {sense_quarter, sense_dime, sense_nickel};

  always_ff @(posedge clk or posedge hrst) begin
    if (hrst) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      deb_d <= '0;
      for (int i = 0; i < 3; i++) cnt[i] <= '0;
    end else if (srst) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      deb_d <= '0;
      for (int i = 0; i < 3; i++) cnt[i] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      deb_d <= deb;
      for (int i = 0; i < 3; i++) begin
        if (sync2[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == DB_LAST) begin
          deb[i] <= sync2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 8'd1;
        end
      end
    end
  end

  logic [2:0]    ev;
  logic          any_ev;
  logic          multi;
  logic [1:0]    code;
  logic          full;
  logic          pop;
  logic          rej;
  logic          push;
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [1:0]    mem [FIFO_DEPTH];

  assign ev     = deb & ~deb_d;
  assign any_ev = |ev;
  assign multi  = (ev[0] & ev[1]) | (ev[0] & ev[2]) | (ev[1] & ev[2]);
  // Single-hot event maps directly: nickel 01, dime 10, quarter 11.
  assign code   = {ev[2] | ev[1], ev[2] | ev[0]};
  assign full   = (fifo_level == FULL);
  assign pop    = (fifo_level != '0) && vm_ready;
  // A pop in the same cycle frees a slot, so a full FIFO can still accept.
  assign rej    = any_ev & (multi | ~accept_en | (full & ~pop));
  assign push   = any_ev & ~rej;

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= code;
  end

  always_ff @(posedge clk or posedge hrst) begin
    if (hrst) begin
      wptr       <= '0;
      rptr       <= '0;
      fifo_level <= '0;
      coins      <= 2'b00;
      reject     <= 1'b0;
    end else if (srst) begin
      wptr       <= '0;
      rptr       <= '0;
      fifo_level <= '0;
      coins      <= 2'b00;
      reject     <= 1'b0;
    end else begin
      reject <= rej;
      coins  <= pop ? mem[rptr] : 2'b00;
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + LW'(1);
        2'b01:   fifo_level <= fifo_level - LW'(1);
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  // Statistics survive a soft reset; only hrst clears them.
  always_ff @(posedge clk or posedge hrst) begin
    if (hrst) begin
      accepted_cnt <= '0;
      rejected_cnt <= '0;
    end else if (!srst) begin
      if (push && accepted_cnt != '1)
        accepted_cnt <= accepted_cnt + CNT_W'(1);
      if (rej && rejected_cnt != '1)
        rejected_cnt <= rejected_cnt + CNT_W'(1);
    end
  end

endmodule

// File: doc/vm_coin_acceptor.md
Name: vm_coin_acceptor

Overview:
Front-end stage directly upstream of the vm2002 user interface. It synchronises and debounces three raw coin-mechanism sensor lines and detects one coin per sensor pulse. Accepted coins are buffered in a small FIFO and delivered to vm2002 as single-cycle 2-bit coin codes on `coins`, one coin per cycle in which the machine is ready. Ambiguous coins, coins arriving while disabled, and coins arriving with the FIFO full are rejected and counted.

Parameters:
DEBOUNCE, 4, consecutive stable cycles required before a sensor level change is accepted (range 2..255)
FIFO_DEPTH, 4, coin buffer entries (power of 2, 2..16)
CNT_W, 8, width of the accepted and rejected statistics counters

Ports:
clk  input  1  system clock, all logic on the rising edge
hrst  input  1  hard reset, asynchronous, active-high; clears all state
srst  input  1  soft reset, synchronous, active-high; flushes FIFO and debouncers, keeps statistics counters
sense_nickel  input  1  raw sensor, asynchronous to clk, may bounce
sense_dime  input  1  raw sensor, asynchronous to clk, may bounce
sense_quarter  input  1  raw sensor, asynchronous to clk, may bounce
accept_en  input  1  vm2002 permits coin intake
vm_ready  input  1  vm2002 can consume a coin this cycle
coins  output  2  coin code to vm2002: 00 none, 01 nickel, 10 dime, 11 quarter (registered)
reject  output  1  one-cycle pulse per rejected coin event (registered)
fifo_level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
accepted_cnt  output  CNT_W  coins pushed into the FIFO, saturating
rejected_cnt  output  CNT_W  coin events rejected, saturating

Behaviour:
- hrst (async) or srst (sync, at the clock edge): coins=00, reject=0, fifo_level=0, FIFO pointers 0, sync flops 0, debounced levels 0, debounce counters 0. accepted_cnt=0 and rejected_cnt=0 on hrst only; srst leaves both unchanged. Reset mid-debounce discards the pending coin.
- Per channel: 2-flop synchroniser sync1->sync2.
- Per channel debounce counter cnt, width 8. Each edge:
  - if sync2==deb: cnt<=0
  - else if cnt==DEBOUNCE-1: deb<=sync2, cnt<=0
  - else: cnt<=cnt+1
  - A glitch shorter than DEBOUNCE cycles never changes deb.
- Coin event = rising edge of deb (deb & ~deb_d, deb_d registered). Falling edges produce nothing. Only one coin is produced per pulse, whatever the pulse length.
- Event resolution in one cycle, in priority order:
  - events on more than one channel in the same cycle: reject all of them (one reject pulse, rejected_cnt+1)
  - accept_en==0: reject
  - FIFO full with no pop in the same cycle: reject
  - otherwise: push the code and increment accepted_cnt
  - Push and pop in the same cycle are allowed, including when the FIFO is full; the level is then unchanged.
- Output stage: when FIFO non-empty and vm_ready==1, coins<=head and pop. Otherwise coins<=00. coins is never non-zero in two consecutive cycles for the same entry.
- Latency: raw line goes high before edge N and is held stable; FIFO empty; vm_ready=1. Then deb rises at edge N+1+DEBOUNCE, the push occurs at edge N+2+DEBOUNCE, and coins shows the code in the cycle after edge N+3+DEBOUNCE (DEBOUNCE=4: 7 edges).
- Pointers wrap modulo FIFO_DEPTH. Full is detected as fifo_level==FIFO_DEPTH.
- Counters saturate at 2^CNT_W-1 and do not wrap.
- No combinational path from any input to any output.

Test Plan:
- Clean dime: sense_dime high for 20 cycles, vm_ready=1, DEBOUNCE=4 -> coins=10 for exactly one cycle, 7 edges after the rise; accepted_cnt=1; reject never asserted.
- Bounce: sense_quarter toggles with high pulses of 1-3 cycles for 30 cycles, then stays low -> coins stays 00, both counters 0. Then a 10-cycle high pulse -> exactly one coins=11.
- Back-pressure and full: vm_ready=0, five separate nickel pulses (FIFO_DEPTH=4) -> fifo_level reaches 4, fifth pulse gives reject=1 and rejected_cnt=1. Then vm_ready=1 -> four coins=01 pulses on consecutive cycles and fifo_level returns to 0.
- Simultaneous: nickel and dime rise in the same cycle and are held -> one reject pulse, rejected_cnt=1, no coin delivered, fifo_level stays 0.
- Disabled: accept_en=0 during a quarter pulse -> reject=1, no push. With accept_en=1 the next quarter is accepted.
- Resets: srst while a coin is mid-debounce and two entries are queued -> fifo_level=0, no coin delivered, accepted_cnt unchanged. hrst asserted asynchronously between clock edges -> all outputs 0 immediately, before the next edge.
